// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// Holds the transmitter state encoding and the oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // s_tick pulses per bit cell (16x oversampling baud tick)
    localparam int OVERSAMPLE = 16;

    // Tick counter width: large enough for stop lengths up to 32 ticks
    localparam int TICK_W = 5;

endpackage

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter draining a fall-through FIFO.
// Produces 8N1 frames by default; defining UART_TX_PARITY_EN inserts one
// even-parity bit between the data bits and the stop bit.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  IDLE   | line high, waiting for a non-empty FIFO; pops and latches byte
//  START  | start bit (line low) for OVERSAMPLE ticks
//  DATA   | data bits LSB first, OVERSAMPLE ticks each
//  PARITY | even parity of the latched byte (UART_TX_PARITY_EN builds only)
//  STOP   | line high for SB_TICK ticks, then back to IDLE
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            tx_empty,
    input  logic [DBIT-1:0] tx_data,
    output logic            tx_rd,
    output logic            tx,
    output logic            tx_busy
);

    localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
    localparam logic [BW-1:0]     DATA_LAST = BW'(DBIT - 1);

    tx_state_t         state;
    logic [TICK_W-1:0] tick_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DBIT-1:0]   shreg;
    logic [DBIT-1:0]   shreg_next;
    logic              tx_reg;
    logic              busy_reg;
`ifdef UART_TX_PARITY_EN
    logic              par_bit;
`endif

    assign shreg_next = shreg >> 1;

    // Pop only from IDLE; held off during reset because the FSM will not
    // latch the byte on that edge and it would otherwise be lost.
    assign tx_rd = (state == IDLE) && !tx_empty && !rst;

    assign tx      = tx_reg;
    assign tx_busy = busy_reg;

    // Frame sequencer: state, counters, shift register and registered line.
    // tx_reg/busy_reg are loaded with the value belonging to the next state
    // so the line changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_reg   <= 1'b1;
            busy_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                    // Start immediately; a tick on this edge is not counted
                    if (!tx_empty) begin
                        shreg    <= tx_data;
`ifdef UART_TX_PARITY_EN
                        par_bit  <= ^tx_data;
`endif
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= START;
                        tx_reg   <= 1'b0;
                        busy_reg <= 1'b1;
                    end
                end

                START: begin
                    if (s_tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            state    <= DATA;
                            tx_reg   <= shreg[0];
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (s_tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= shreg_next;
                            if (bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                                state  <= PARITY;
                                tx_reg <= par_bit;
`else
                                state  <= STOP;
                                tx_reg <= 1'b1;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                tx_reg  <= shreg_next[0];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            state    <= STOP;
                            tx_reg   <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`endif

                STOP: begin
                    if (s_tick) begin
                        if (tick_cnt == STOP_LAST) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                            tx_reg   <= 1'b1;
                            busy_reg <= 1'b0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: FIFO model feeds the DUT, pops push the
// expected byte into a scoreboard, and an independent line monitor decodes
// frames by counting s_tick pulses and sampling each bit cell mid-way.
module tb_uart_tx;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_TICKS = (1 + DBIT + PAR) * 16 + SB_TICK;
    localparam int STOP_SLOT   = DBIT + 1 + PAR;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_tick = 1'b0;
    logic            tx_empty = 1'b1;
    logic [DBIT-1:0] tx_data = '0;
    logic            tx_rd;
    logic            tx;
    logic            tx_busy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] fifo[$];
    logic [7:0] exp_q[$];

    int tick_period = 1;
    int tick_ph = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int last_rd_cyc = -1;
    int want_spacing = 0;
    int busy_chk = 0;
    bit pop_pending = 1'b0;

    bit          mon_active = 1'b0;
    int          tick_idx = 0;
    bit          tick_new = 1'b0;
    int          busy_clks = 0;
    logic [15:0] samp = '0;

    uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tick   (s_tick),
        .tx_empty (tx_empty),
        .tx_data  (tx_data),
        .tx_rd    (tx_rd),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic refresh();
        tx_empty = (fifo.size() == 0);
        tx_data  = (fifo.size() == 0) ? '0 : fifo[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        refresh();
    endtask

    always @(posedge clk) cyc++;

    // Baud tick source: every tick_period clocks
    always @(posedge clk) begin
        #1;
        if (tick_period <= 1) begin
            s_tick = 1'b1;
        end else begin
            s_tick  = (tick_ph == 0);
            tick_ph = (tick_ph + 1) % tick_period;
        end
    end

    // FIFO read side: observe pop strobe away from the edge, pop after it
    always @(negedge clk) begin
        if (tx_rd) begin
            check("rd_while_empty", {31'd0, tx_empty}, 32'd0);
            if (want_spacing != 0 && last_rd_cyc >= 0)
                check("rd_spacing", cyc - last_rd_cyc, want_spacing);
            last_rd_cyc = cyc;
            rd_cnt++;
            pop_pending = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (pop_pending) begin
            pop_pending = 1'b0;
            if (fifo.size() > 0) exp_q.push_back(fifo.pop_front());
            refresh();
        end
    end

    // Line monitor: decode frames and compare with the scoreboard
    always @(negedge clk) begin
        logic [7:0] e;
        logic [7:0] dec;
        int slot;
        if (rst) begin
            if (mon_active && exp_q.size() > 0) void'(exp_q.pop_front());
            mon_active = 1'b0;
        end else begin
            if (!mon_active && tx_busy) begin
                mon_active = 1'b1;
                tick_idx   = 0;
                tick_new   = 1'b0;
                busy_clks  = 0;
                samp       = '1;
                check("start_latency_tx", {31'd0, tx}, 32'd0);
            end
            if (mon_active) begin
                if (tx_busy) begin
                    busy_clks++;
                    if (tick_new && (tick_idx % 16) == 8) begin
                        slot = tick_idx / 16;
                        if (slot < 16) samp[slot] = tx;
                    end
                    tick_new = 1'b0;
                    if (s_tick) begin
                        tick_idx++;
                        tick_new = 1'b1;
                    end
                end else begin
                    check("frame_ticks", tick_idx, FRAME_TICKS);
                    if (busy_chk == 1)
                        check("busy_clks", busy_clks, FRAME_TICKS);
                    else if (busy_chk > 1)
                        check("busy_clks_range",
                              {31'd0, (busy_clks > (FRAME_TICKS - 1) * busy_chk) &&
                                      (busy_clks <= FRAME_TICKS * busy_chk)}, 32'd1);
                    check("start_bit", {31'd0, samp[0]}, 32'd0);
                    dec = samp[DBIT:1];
                    if (exp_q.size() == 0) begin
                        check("frame_without_pop", {24'd0, dec}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("data_byte", {24'd0, dec}, {24'd0, e});
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", {31'd0, samp[DBIT+1]}, {31'd0, ^e});
`endif
                    end
                    check("stop_bit", {31'd0, samp[STOP_SLOT]}, 32'd1);
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while ((fifo.size() != 0 || tx_busy || mon_active || pop_pending) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_budget", {31'd0, n < budget}, 32'd1);
    endtask

    initial begin
        int r0;
        int n;
        logic [7:0] b;

        refresh();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, tx_busy}, 32'd0);
        check("reset_rd", {31'd0, tx_rd}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Empty FIFO, tick every clock: line must stay idle
        tick_period = 1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            check("idle_tx", {31'd0, tx}, 32'd1);
            check("idle_busy", {31'd0, tx_busy}, 32'd0);
            check("idle_rd", {31'd0, tx_rd}, 32'd0);
        end

        // Single byte 0xA5
        busy_chk = 1;
        r0 = rd_cnt;
        @(posedge clk); #1 push(8'hA5);
        wait_idle(FRAME_TICKS + 50);
        check("a5_rd_pulses", rd_cnt - r0, 1);

        // Back-to-back 0x55, 0x0F
        r0 = rd_cnt;
        last_rd_cyc = -1;
        want_spacing = FRAME_TICKS + 1;
        @(posedge clk); #1 push(8'h55); push(8'h0F);
        wait_idle(2 * FRAME_TICKS + 50);
        check("b2b_rd_pulses", rd_cnt - r0, 2);
        want_spacing = 0;

        // Slow tick: one s_tick every 4 clocks
        tick_period = 4;
        busy_chk = 4;
        @(posedge clk); #1 push(8'h3C);
        wait_idle(FRAME_TICKS * 4 + 50);

        // Odd-weight byte (parity 1 when enabled)
        tick_period = 1;
        busy_chk = 1;
        @(posedge clk); #1 push(8'h07);
        wait_idle(FRAME_TICKS + 50);

        // Random bytes, tick rates and FIFO writes during frames
        busy_chk = 0;
        for (int i = 0; i < 24; i++) begin
            tick_period = $urandom_range(1, 3);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            @(posedge clk); #1 push(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 200)) @(posedge clk);
                #1 push(8'($urandom));
            end
            wait_idle(2 * FRAME_TICKS * 3 + 100);
        end

        // Reset during the 4th data bit
        tick_period = 1;
        r0 = rd_cnt;
        b = 8'hC3;
        @(posedge clk); #1 push(b);
        n = 0;
        while (rd_cnt == r0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_popped", {31'd0, n < 20}, 32'd1);
        @(posedge clk);
        repeat (68) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midframe_rst_tx", {31'd0, tx}, 32'd1);
        check("midframe_rst_busy", {31'd0, tx_busy}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i % 50 == 0) check("post_rst_tx", {31'd0, tx}, 32'd1);
        end
        check("post_rst_rd_count", rd_cnt - r0, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
